// File: rtl/truth_table_probe.sv
// truth_table_probe
//   Walks a 3-input combinational DUT through all eight input rows, holds each
//   row for SETTLE_CYCLES cycles, samples the DUT output at the end of the
//   row and assembles an 8-bit truth-table code (row 000 -> MSB, row 111 -> LSB).
//   The code is compared against a reference latched when the scan starts.
//
//   Ports
//     clk_i            clock, rising edge
//     rst_i            synchronous active-high reset
//     start_i          scan request, accepted only in IDLE
//     expected_i       reference code, latched on start acceptance
//     probe_in_o       {in1,in2,in3} driven to the DUT (row index while scanning)
//     probe_out_i      DUT output
//     busy_o           high while scanning
//     done_o           one-cycle pulse, results valid in that cycle
//     table_code_o     measured truth-table code (held until next done/reset)
//     match_o          table_code == latched expected
//     mismatch_mask_o  table_code ^ latched expected
module truth_table_probe #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] expected_i,
    output logic [2:0] probe_in_o,
    input  logic       probe_out_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] table_code_o,
    output logic       match_o,
    output logic [7:0] mismatch_mask_o
);

    // Counter holds 0..SETTLE_CYCLES-1 within a row.
    localparam int            CW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    state_e        state_q, state_d;
    logic [2:0]    row_q,   row_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [7:0]    acc_q,   acc_d;
    logic [7:0]    exp_q,   exp_d;
    logic [7:0]    code_q,  code_d;
    logic          match_q, match_d;
    logic [7:0]    mask_q,  mask_d;

    // Rows are shifted in MSB-first, so after eight samples row 0 sits in
    // bit 7 and row 7 in bit 0.
    logic [7:0] shifted;
    assign shifted = {acc_q[6:0], probe_out_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            row_q   <= 3'd0;
            cnt_q   <= '0;
            acc_q   <= 8'h00;
            exp_q   <= 8'h00;
            code_q  <= 8'h00;
            match_q <= 1'b0;
            mask_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            exp_q   <= exp_d;
            code_q  <= code_d;
            match_q <= match_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        exp_d   = exp_q;
        code_d  = code_q;
        match_d = match_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SCAN;
                    row_d   = 3'd0;
                    cnt_d   = '0;
                    acc_d   = 8'h00;
                    exp_d   = expected_i;
                end
            end
            SCAN: begin
                if (cnt_q == LAST) begin
                    // Last settle cycle of this row: sample and move on.
                    acc_d = shifted;
                    cnt_d = '0;
                    if (row_q == 3'd7) begin
                        state_d = DONE;
                        row_d   = 3'd0;
                        // Results are registered on the edge into DONE so they
                        // are valid during the done pulse.
                        code_d  = shifted;
                        match_d = (shifted == exp_q);
                        mask_d  = shifted ^ exp_q;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign probe_in_o      = (state_q == SCAN) ? row_q : 3'b000;
    assign busy_o          = (state_q == SCAN);
    assign done_o          = (state_q == DONE);
    assign table_code_o    = code_q;
    assign match_o         = match_q;
    assign mismatch_mask_o = mask_q;

endmodule

// File: tb/tb_truth_table_probe.sv
// Bench for truth_table_probe: three instances (SETTLE_CYCLES 4, 2, 1) share
// stimulus; each drives its own behavioural DUT (truth table + optional
// 3-cycle output delay). Expected results are queued at start time and
// checked by a monitor when done pulses.
module tb_truth_table_probe;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start;
    logic [7:0] expected;
    logic [2:0] en;

    logic [2:0] pin   [3];
    logic       pout  [3];
    logic       busy  [3];
    logic       done  [3];
    logic       match [3];
    logic [7:0] code  [3];
    logic [7:0] mask  [3];

    truth_table_probe #(.SETTLE_CYCLES(4)) u_s4 (
        .clk_i(clk), .rst_i(rst), .start_i(start & en[0]), .expected_i(expected),
        .probe_in_o(pin[0]), .probe_out_i(pout[0]), .busy_o(busy[0]), .done_o(done[0]),
        .table_code_o(code[0]), .match_o(match[0]), .mismatch_mask_o(mask[0]));
    truth_table_probe #(.SETTLE_CYCLES(2)) u_s2 (
        .clk_i(clk), .rst_i(rst), .start_i(start & en[1]), .expected_i(expected),
        .probe_in_o(pin[1]), .probe_out_i(pout[1]), .busy_o(busy[1]), .done_o(done[1]),
        .table_code_o(code[1]), .match_o(match[1]), .mismatch_mask_o(mask[1]));
    truth_table_probe #(.SETTLE_CYCLES(1)) u_s1 (
        .clk_i(clk), .rst_i(rst), .start_i(start & en[2]), .expected_i(expected),
        .probe_in_o(pin[2]), .probe_out_i(pout[2]), .busy_o(busy[2]), .done_o(done[2]),
        .table_code_o(code[2]), .match_o(match[2]), .mismatch_mask_o(mask[2]));

    function automatic int s_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 2 : 1;
    endfunction

    // Behavioural DUT: tt[7-r] is the output for input row r.
    logic [7:0] tt;
    int         dly;
    logic [2:0] pipe [3];

    always @(posedge clk)
        for (int i = 0; i < 3; i++) pipe[i] <= {pipe[i][1:0], tt[3'd7 - pin[i]]};

    always_comb
        for (int i = 0; i < 3; i++) pout[i] = (dly != 0) ? pipe[i][2] : tt[3'd7 - pin[i]];

    // Reference: row r is sampled at scan cycle r*s+s-1; with a delay of d the
    // DUT shows the row driven d cycles earlier (row 0 before the scan).
    function automatic logic [7:0] ref_code(input logic [7:0] t, input int s, input int d);
        logic [7:0] c;
        c = 8'h00;
        for (int r = 0; r < 8; r++) begin
            int k, row;
            k   = r * s + s - 1 - d;
            row = (k < 0) ? 0 : k / s;
            c[7 - r] = t[7 - row];
        end
        return c;
    endfunction

    typedef struct {
        int unsigned dcyc;
        logic [7:0]  code;
        logic [7:0]  expv;
    } exp_t;

    exp_t        sbq [3][$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    logic        rst_seen = 1'b0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", nm, i, cyc, act, want);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Monitor
    int         bcnt       [3];
    logic [7:0] hold_code  [3];
    logic [7:0] hold_mask  [3];
    logic       hold_match [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            if (rst_seen) begin
                sbq[i].delete();
                bcnt[i]       = 0;
                hold_code[i]  = 8'h00;
                hold_mask[i]  = 8'h00;
                hold_match[i] = 1'b0;
                chk("rst_busy", i, 32'(busy[i]), 32'd0);
                chk("rst_done", i, 32'(done[i]), 32'd0);
            end
            if (busy[i]) begin
                chk("probe_row", i, 32'(pin[i]), 32'(bcnt[i] / s_of(i)));
                bcnt[i]++;
            end else begin
                chk("probe_idle", i, 32'(pin[i]), 32'd0);
            end
            if (done[i] === 1'b1) begin
                if (sbq[i].size() == 0) begin
                    chk("unexpected_done", i, 32'd1, 32'd0);
                end else begin
                    e = sbq[i].pop_front();
                    chk("done_cycle", i, e.dcyc, cyc);
                    chk("busy_len", i, 32'(bcnt[i]), 32'(8 * s_of(i)));
                    hold_code[i]  = e.code;
                    hold_mask[i]  = e.code ^ e.expv;
                    hold_match[i] = (e.code == e.expv);
                end
                bcnt[i] = 0;
            end
            chk("table_code", i, 32'(code[i]), 32'(hold_code[i]));
            chk("match", i, 32'(match[i]), 32'(hold_match[i]));
            chk("mismatch_mask", i, 32'(mask[i]), 32'(hold_mask[i]));
            if (sbq[i].size() != 0 && cyc > sbq[i][0].dcyc) begin
                chk("done_missing", i, cyc, sbq[i][0].dcyc);
                void'(sbq[i].pop_front());
            end
        end
    end

    task automatic push_exp(input int i, input int unsigned dc, input logic [7:0] c, input logic [7:0] e);
        exp_t x;
        x.dcyc = dc;
        x.code = c;
        x.expv = e;
        sbq[i].push_back(x);
    endtask

    // One scan on the instances selected by m; start/expected are jiggled
    // while every selected instance is still scanning (must be ignored).
    task automatic run_scan(input logic [7:0] t, input logic [7:0] e, input int d, input logic [2:0] m);
        tt  = t;
        dly = d;
        repeat (4) @(negedge clk);
        start    = 1'b1;
        expected = e;
        en       = m;
        for (int i = 0; i < 3; i++)
            if (m[i]) push_exp(i, cyc + 1 + 8 * s_of(i), ref_code(t, s_of(i), d), e);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            start    = ($urandom % 3 == 0);
            expected = 8'($urandom);
        end
        start = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        expected = 8'h00;
        en       = 3'b000;
        tt       = 8'h00;
        dly      = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reference DUT 0x71: matching and fully inverted expectations.
        run_scan(8'h71, 8'h71, 0, 3'b111);
        run_scan(8'h71, 8'h8E, 0, 3'b111);
        // Delayed DUT: long settle survives, shorter settle sees stale rows.
        run_scan(8'h71, 8'h71, 3, 3'b111);

        // Abort during row 3 of the 4-cycle instance; no done may follow.
        tt  = 8'hFF;
        dly = 0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        expected = 8'hFF;
        en = 3'b001;
        push_exp(0, cyc + 33, 8'hFF, 8'hFF);
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_scan(8'hFF, 8'hFF, 0, 3'b111);

        // Reset wins over a simultaneous start.
        rst = 1'b1;
        start = 1'b1;
        en = 3'b111;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);

        // Start held high on the 1-cycle instance: two back-to-back scans.
        tt  = 8'($urandom);
        dly = 0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        expected = 8'h5A;
        en = 3'b100;
        push_exp(2, cyc + 9, tt, 8'h5A);
        push_exp(2, cyc + 19, tt, 8'h5A);
        repeat (11) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);

        // Random tables, expectations and delays.
        for (int n = 0; n < 12; n++) begin
            logic [7:0] t;
            t = 8'($urandom);
            run_scan(t, ($urandom % 2 == 0) ? t : 8'($urandom), ($urandom % 2 == 0) ? 0 : 3, 3'b111);
        end

        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("queue_empty", i, sbq[i].size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
